memory_arbiter: RTL

- Shares a single word-wide RAM port between the instruction-fetch and data-access request streams of the processor datapath.
- Grants one requester at a time and holds the grant until the RAM reports completion.
- Returns wait/load data to the granted side.
- Data requests have priority; a starvation counter forces an instruction grant after a bounded run of data grants.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/memory_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types for the memory arbiter
// Purpose: word type, RAM handshake state encoding and arbiter FSM states.
// Ports: none (package).
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one RAM port between instruction fetch and data access
// Purpose: grants one requester at a time, data first, with a starvation
//          counter that forces an instruction grant after STARVE_LIMIT
//          consecutive data completions while an instruction fetch waits.
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   iREN, iaddr               instruction read request / address
//   iwait, iload              instruction wait flag / returned data
//   dREN, dWEN, daddr, dstore data read/write request, address, write data
//   dwait, dload              data wait flag / returned data
//   ramREN, ramWEN            RAM strobes
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / RAM handshake state
//   ram_err                   sticky flag, set by any ERROR completion
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WORD_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             ram_err_q;

  ramstate_t rs;
  logic      dreq;
  logic      done;
  logic      starve_hit;

  assign rs         = ramstate_t'(ramstate);
  assign dreq       = dREN | dWEN;
  // ERROR ends the access just like ACCESS so the requester never hangs.
  assign done       = (rs == ACCESS) || (rs == ERROR);
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign ram_err    = ram_err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ram_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !(iREN && starve_hit)) state <= DGRANT;
          else if (iREN)                     state <= IGRANT;
        end
        DGRANT: begin
          if (!dreq) begin
            // Request withdrawn before completion: abandon silently.
            state <= IDLE;
          end else if (done) begin
            state <= IDLE;
            if (!iREN)            starve_cnt <= '0;
            else if (!starve_hit) starve_cnt <= starve_cnt + CNT_W'(1);
            if (rs == ERROR) ram_err_q <= 1'b1;
          end
        end
        IGRANT: begin
          if (!iREN) begin
            state <= IDLE;
          end else if (done) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if (rs == ERROR) ram_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and wait/load follow the live request so a dropped request
  // releases the RAM in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    case (state)
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (dreq && done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iREN ? iaddr : '0;
        if (iREN && done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule
